// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the request fault check evaluated at accept time.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} lsu_state_t;

    // Misaligned, out-of-range or illegal-funct3 request; limit is the first invalid byte address.
    function automatic logic lsu_fault(input logic        we,
                                       input logic [2:0]  funct3,
                                       input logic [31:0] addr,
                                       input logic [31:0] limit);
        logic illegal;
        logic misaligned;
        if (we)
            illegal = (funct3 > F3_W);
        else
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        return illegal || misaligned || (addr >= limit);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane steering: load extraction/extension and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] store_data,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'b0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'b0, half_sel};
            default: load_data = word;
        endcase

        // Bytes outside the written lane keep the value just read from memory.
        store_word = word;
        case (funct3[1:0])
            2'b00: store_word[{offset, 3'b000} +: 8] = store_data[7:0];
            2'b01: begin
                if (offset[1])
                    store_word[31:16] = store_data[15:0];
                else
                    store_word[15:0] = store_data[15:0];
            end
            default: store_word = store_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns byte-addressed core requests into word memory
// transactions, with read-modify-write for SB/SH and extended loads.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_ADDR_W = 16,
    parameter int MEM_WORDS  = 2048
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [31:0]           resp_rdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    output logic [MEM_ADDR_W-1:0] mem_waddr,
    output logic [MEM_ADDR_W-1:0] mem_raddr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

    lsu_state_t state, state_next;

    logic                  we_q;
    logic [2:0]            funct3_q;
    logic [1:0]            offset_q;
    logic [MEM_ADDR_W-1:0] word_addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic                  fault;
    logic                  accept;
    logic [31:0]           load_data;
    logic [31:0]           store_word;

    assign fault  = lsu_fault(req_we, req_funct3, req_addr, ADDR_LIMIT);
    assign accept = (state == IDLE) && req_valid;

    lsu_align u_align (
        .word       (mem_rdata),
        .store_data (wdata_q),
        .offset     (offset_q),
        .funct3     (funct3_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (fault)
                        state_next = RESP;
                    else if (req_we && (req_funct3 == F3_W))
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD: begin
                mem_ren    = 1'b1;
                state_next = RD_WAIT;
            end
            RD_WAIT: state_next = we_q ? WR : RESP;
            WR: begin
                mem_wen    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = rdata_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_raddr = word_addr_q;
    assign mem_waddr = word_addr_q;
    assign mem_wdata = wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            funct3_q    <= 3'b0;
            offset_q    <= 2'b0;
            word_addr_q <= '0;
            wdata_q     <= 32'b0;
            rdata_q     <= 32'b0;
            err_q       <= 1'b0;
        end else if (accept) begin
            we_q        <= req_we;
            funct3_q    <= req_funct3;
            offset_q    <= req_addr[1:0];
            word_addr_q <= req_addr[MEM_ADDR_W+1:2];
            wdata_q     <= req_wdata;
            rdata_q     <= 32'b0;
            err_q       <= fault;
        end else if (state == RD_WAIT) begin
            // Read data arrives here: stores merge into the write word, loads capture the result.
            if (we_q)
                wdata_q <= store_word;
            else
                rdata_q <= load_data;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 1-cycle registered memory model.
module tb_load_store_unit;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_WORDS  = 2048;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic                  req_we = 1'b0;
    logic [2:0]            req_funct3 = 3'b0;
    logic [31:0]           req_addr = 32'b0;
    logic [31:0]           req_wdata = 32'b0;
    logic                  resp_valid;
    logic                  resp_err;
    logic [31:0]           resp_rdata;
    logic                  mem_wen;
    logic                  mem_ren;
    logic [MEM_ADDR_W-1:0] mem_waddr;
    logic [MEM_ADDR_W-1:0] mem_raddr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata = 32'b0;

    logic [31:0] mem [MEM_WORDS];

    int tests_run = 0;
    int tests_failed = 0;

    int          r_resp_cyc, r_resp_cnt, r_ren_cyc, r_ren_cnt, r_wen_cyc, r_wen_cnt;
    logic [31:0] r_rdata, r_wen_wdata;
    logic        r_err, r_both;
    logic [MEM_ADDR_W-1:0] r_wen_waddr;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_ADDR_W(MEM_ADDR_W), .MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_waddr(mem_waddr),
        .mem_raddr(mem_raddr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_wen) mem[mem_waddr[10:0]] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem[mem_raddr[10:0]];
    end

    // Issue one request (accept edge = end of T0) and record what happens over cycles T1..T8.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        r_resp_cyc = -1; r_resp_cnt = 0; r_ren_cyc = -1; r_ren_cnt = 0;
        r_wen_cyc = -1; r_wen_cnt = 0; r_rdata = 32'hx; r_err = 1'bx; r_both = 1'b0;
        r_wen_wdata = 32'hx; r_wen_waddr = 'x;
        for (int c = 1; c <= 8; c++) begin
            if (mem_ren) begin r_ren_cnt++; if (r_ren_cyc < 0) r_ren_cyc = c; end
            if (mem_wen) begin r_wen_cnt++; r_wen_cyc = c; r_wen_wdata = mem_wdata; r_wen_waddr = mem_waddr; end
            if (mem_ren && mem_wen) r_both = 1'b1;
            if (resp_valid) begin
                r_resp_cnt++;
                if (r_resp_cyc < 0) begin r_resp_cyc = c; r_rdata = resp_rdata; r_err = resp_err; end
            end
            if (c < 8) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({mem_wen, mem_ren, resp_valid, resp_err} !== 4'b0) begin
            tests_failed++; $display("FAIL reset_strobes got %b exp 0000", {mem_wen, mem_ren, resp_valid, resp_err});
        end
        tests_run++;
        if ({resp_rdata, mem_wdata, mem_waddr, mem_raddr} !== '0) begin
            tests_failed++; $display("FAIL reset_data got rdata=%h wdata=%h waddr=%h raddr=%h exp 0",
                                     resp_rdata, mem_wdata, mem_waddr, mem_raddr);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_lb_lbu();
        mem[5] = 32'h80AB_CD12;
        run_req(1'b0, 3'b000, 32'h17, 32'h0);
        tests_run++;
        if (r_resp_cyc !== 3) begin tests_failed++; $display("FAIL lb_latency got %0d exp 3", r_resp_cyc); end
        tests_run++;
        if (r_rdata !== 32'hFFFF_FF80 || r_err !== 1'b0) begin
            tests_failed++; $display("FAIL lb_data got %h err=%b exp ffffff80 err=0", r_rdata, r_err);
        end
        tests_run++;
        if (r_ren_cyc !== 1 || r_wen_cnt !== 0) begin
            tests_failed++; $display("FAIL lb_strobes got ren@%0d wen_cnt=%0d exp ren@1 wen_cnt=0", r_ren_cyc, r_wen_cnt);
        end
        run_req(1'b0, 3'b100, 32'h17, 32'h0);
        tests_run++;
        if (r_rdata !== 32'h0000_0080 || r_resp_cyc !== 3) begin
            tests_failed++; $display("FAIL lbu_data got %h @%0d exp 00000080 @3", r_rdata, r_resp_cyc);
        end
    endtask

    task automatic test_sw_lw();
        run_req(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF);
        tests_run++;
        if (r_wen_cyc !== 1 || r_wen_cnt !== 1 || r_wen_waddr !== 16'd8 || r_wen_wdata !== 32'hDEAD_BEEF) begin
            tests_failed++; $display("FAIL sw_write got wen@%0d cnt=%0d waddr=%0d wdata=%h exp wen@1 cnt=1 waddr=8 wdata=deadbeef",
                                     r_wen_cyc, r_wen_cnt, r_wen_waddr, r_wen_wdata);
        end
        tests_run++;
        if (r_resp_cyc !== 2 || r_resp_cnt !== 1 || r_ren_cnt !== 0 || r_rdata !== 32'h0 || r_err !== 1'b0) begin
            tests_failed++; $display("FAIL sw_resp got resp@%0d cnt=%0d ren_cnt=%0d rdata=%h err=%b exp resp@2 cnt=1 ren_cnt=0 rdata=0 err=0",
                                     r_resp_cyc, r_resp_cnt, r_ren_cnt, r_rdata, r_err);
        end
        run_req(1'b0, 3'b010, 32'h20, 32'h0);
        tests_run++;
        if (r_rdata !== 32'hDEAD_BEEF || r_resp_cyc !== 3) begin
            tests_failed++; $display("FAIL lw_data got %h @%0d exp deadbeef @3", r_rdata, r_resp_cyc);
        end
    endtask

    task automatic test_sb_rmw();
        mem[2] = 32'h1122_3344;
        run_req(1'b1, 3'b000, 32'h09, 32'h0000_00AA);
        tests_run++;
        if (r_ren_cyc !== 1 || r_wen_cyc !== 3 || r_wen_wdata !== 32'h1122_AA44 || r_wen_waddr !== 16'd2) begin
            tests_failed++; $display("FAIL sb_rmw got ren@%0d wen@%0d wdata=%h waddr=%0d exp ren@1 wen@3 wdata=1122aa44 waddr=2",
                                     r_ren_cyc, r_wen_cyc, r_wen_wdata, r_wen_waddr);
        end
        tests_run++;
        if (r_resp_cyc !== 4 || r_both !== 1'b0) begin
            tests_failed++; $display("FAIL sb_resp got resp@%0d both=%b exp resp@4 both=0", r_resp_cyc, r_both);
        end
        tests_run++;
        if (mem[2] !== 32'h1122_AA44) begin tests_failed++; $display("FAIL sb_mem got %h exp 1122aa44", mem[2]); end
    endtask

    task automatic test_sh_lh();
        mem[3] = 32'h0;
        run_req(1'b1, 3'b001, 32'h0E, 32'h0000_8001);
        tests_run++;
        if (mem[3] !== 32'h8001_0000 || r_resp_cyc !== 4) begin
            tests_failed++; $display("FAIL sh_mem got %h @%0d exp 80010000 @4", mem[3], r_resp_cyc);
        end
        run_req(1'b0, 3'b001, 32'h0E, 32'h0);
        tests_run++;
        if (r_rdata !== 32'hFFFF_8001) begin tests_failed++; $display("FAIL lh_data got %h exp ffff8001", r_rdata); end
        run_req(1'b0, 3'b101, 32'h0E, 32'h0);
        tests_run++;
        if (r_rdata !== 32'h0000_8001) begin tests_failed++; $display("FAIL lhu_data got %h exp 00008001", r_rdata); end
    endtask

    task automatic test_faults();
        logic        we_t   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3_t   [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b011};
        logic [31:0] addr_t [5] = '{32'h2, 32'h5, 32'h2000, 32'h0, 32'h4};
        for (int i = 0; i < 5; i++) begin
            run_req(we_t[i], f3_t[i], addr_t[i], 32'hFFFF_FFFF);
            tests_run++;
            if (r_resp_cyc !== 1 || r_err !== 1'b1 || r_rdata !== 32'h0 || r_ren_cnt !== 0 || r_wen_cnt !== 0) begin
                tests_failed++; $display("FAIL fault_%0d got resp@%0d err=%b rdata=%h ren=%0d wen=%0d exp resp@1 err=1 rdata=0 ren=0 wen=0",
                                         i, r_resp_cyc, r_err, r_rdata, r_ren_cnt, r_wen_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        mem[4] = 32'h5566_7788;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h99;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({mem_wen, mem_ren, resp_valid, resp_err} !== 4'b0 || {resp_rdata, mem_wdata, mem_waddr, mem_raddr} !== '0) begin
            tests_failed++; $display("FAIL midreset_outputs got wen=%b ren=%b rv=%b wdata=%h waddr=%h exp all 0",
                                     mem_wen, mem_ren, resp_valid, mem_wdata, mem_waddr);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (req_ready !== 1'b1 || mem[4] !== 32'h5566_7788) begin
            tests_failed++; $display("FAIL midreset_after got ready=%b mem4=%h exp ready=1 mem4=55667788", req_ready, mem[4]);
        end
    endtask

    task automatic test_back_to_back();
        int ren_n = 0, resp_n = 0, ready_n = 0, bad_data = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (mem_ren) ren_n++;
            if (req_ready) ready_n++;
            if (resp_valid) begin
                resp_n++;
                if (resp_rdata !== 32'hDEAD_BEEF || (c % 4) != 3) bad_data++;
            end
        end
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        tests_run++;
        if (ren_n !== 3 || resp_n !== 3 || ready_n !== 3 || bad_data !== 0) begin
            tests_failed++; $display("FAIL back_to_back got ren=%0d resp=%0d ready=%0d bad=%0d exp 3 3 3 0",
                                     ren_n, resp_n, ready_n, bad_data);
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
        test_reset();
        test_lb_lbu();
        test_sw_lw();
        test_sb_rmw();
        test_sh_lh();
        test_faults();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
